cpu_mem_responder: RTL

Unified instruction/data memory responder that sits on the far side of the `cpu` memory interface. It answers the CPU's instruction fetches on `pc` and its data loads/stores on `aluout`/`writedata`/`memwrite`/`memread`, returning `instr` and `readdata`. It is built around one single-ported word array, so a data access costs one extra cycle, which it signals with `stall`. It replaces the hand-driven `instr`/`readdata` stimulus in CPU-level benches and is the memory used at the top level.

---
 rtl/cpu_mem_responder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: unified instruction/data memory behind a single-ported
// word array. Instruction fetches are answered combinationally; a data load or
// store costs one stall cycle because the port is shared with the fetch.
// Optional MMIO (cycle counter read at all-ones, done flag written at
// all-ones-minus-one) is enabled by defining CPU_MEM_MMIO_EN.
module cpu_mem_responder #(
  parameter int unsigned n          = 16,
  parameter int unsigned addr_width = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] pc,
  input  logic [n-1:0] aluout,
  input  logic [n-1:0] writedata,
  input  logic         memwrite,
  input  logic         memread,
  output logic [n-1:0] instr,
  output logic [n-1:0] readdata,
  output logic         stall,
  output logic         done
);

  localparam int unsigned depth = 1 << addr_width;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } state_t;

  state_t                state;
  logic [n-1:0]          mem [depth];
  logic [n-1:0]          instr_q;
  logic [n-1:0]          rd_q;
  logic [addr_width-1:0] port_addr;
  logic [n-1:0]          port_rd;
  logic [n-1:0]          load_val;
  logic                  mmio_wr_hit;

  // Address bits above the array index are ignored, so addresses alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{pc[n-1:addr_width], aluout[n-1:addr_width]};

  // The single port serves the fetch in FETCH and the data access otherwise.
  assign port_addr = (state == FETCH) ? pc[addr_width-1:0] : aluout[addr_width-1:0];
  assign port_rd   = mem[port_addr];

`ifdef CPU_MEM_MMIO_EN
  logic [n-1:0] cyc;
  logic         mmio_rd_hit;

  assign mmio_rd_hit = (aluout == {n{1'b1}});
  assign mmio_wr_hit = (aluout == ~n'(1));
  assign load_val    = mmio_rd_hit ? cyc : port_rd;

  // Free-running cycle counter and the program-complete flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc  <= '0;
      done <= 1'b0;
    end else begin
      cyc <= cyc + n'(1);
      if (state == STORE && mmio_wr_hit) begin
        done <= writedata[0];
      end
    end
  end
`else
  assign mmio_wr_hit = 1'b0;
  assign load_val    = port_rd;
  assign done        = 1'b0;
`endif

  // Array write at the end of a STORE cycle; reset drops an in-flight store.
  always_ff @(posedge clk) begin
    if (!reset && state == STORE && !mmio_wr_hit) begin
      mem[aluout[addr_width-1:0]] <= writedata;
    end
  end

  // Access FSM: holds the fetched instruction across the data cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      instr_q <= '0;
      rd_q    <= '0;
    end else begin
      case (state)
        FETCH: begin
          instr_q <= port_rd;
          if (memwrite) begin
            state <= STORE;
          end else if (memread) begin
            state <= LOAD;
          end else begin
            state <= FETCH;
          end
        end
        LOAD: begin
          rd_q  <= load_val;
          state <= FETCH;
        end
        STORE: begin
          state <= FETCH;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  // Output muxing; everything reads as zero while reset is held.
  always_comb begin
    instr    = '0;
    readdata = '0;
    stall    = 1'b0;
    if (!reset) begin
      readdata = rd_q;
      case (state)
        FETCH: begin
          instr = port_rd;
          stall = memread | memwrite;
        end
        LOAD: begin
          instr    = instr_q;
          readdata = load_val;
        end
        STORE: begin
          instr = instr_q;
        end
        default: begin
          instr = '0;
        end
      endcase
    end
  end

endmodule
